// File: rtl/cp0_except_commit.sv
// CP0 register file with exception/ERET commit, Count/Compare timer and interrupt pending logic.
// The except_req and cp0_regs records are carried as flat except_* / cp0_* ports.
module cp0_except_commit #(
  parameter logic [31:0] EBASE_RESET = 32'h8000_0000,
  parameter int unsigned COUNT_DIV   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        except_valid,
  input  logic        except_eret,
  input  logic [4:0]  except_code,
  input  logic [31:0] except_extra,
  input  logic [31:0] except_pc,
  input  logic        except_delayslot,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  input  logic [5:0]  hw_int,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic [31:0] cp0_error_epc,
  output logic [31:0] cp0_ebase,
  output logic [7:0]  interrupt_req
);

  localparam logic [7:0] KeyBadVAddr = {5'd8, 3'd0};
  localparam logic [7:0] KeyCount    = {5'd9, 3'd0};
  localparam logic [7:0] KeyCompare  = {5'd11, 3'd0};
  localparam logic [7:0] KeyStatus   = {5'd12, 3'd0};
  localparam logic [7:0] KeyCause    = {5'd13, 3'd0};
  localparam logic [7:0] KeyEpc      = {5'd14, 3'd0};
  localparam logic [7:0] KeyEbase    = {5'd15, 3'd1};
  localparam logic [7:0] KeyErrorEpc = {5'd30, 3'd0};

  // Status fields
  logic        bev_q, bev_d, erl_q, erl_d, exl_q, exl_d, ie_q, ie_d;
  logic [7:0]  im_q, im_d;
  // Cause fields
  logic        bd_q, bd_d, ti_q, ti_d, iv_q, iv_d;
  logic [7:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // Full-width registers
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic [31:0] epc_q, epc_d, error_epc_q, error_epc_d, badvaddr_q, badvaddr_d;
  logic [17:0] ebase_q, ebase_d;
  logic        div_q, div_d;
  logic [5:0]  hw_int_q;
  logic [7:0]  interrupt_req_q, interrupt_req_d;

  logic [7:0]  wr_key, rd_key;
  logic        mtc0, commit, eret, tick, count_wr, compare_wr, ti_set;
  logic [31:0] count_inc;
  logic [31:0] status_word, cause_word;

  assign wr_key     = {wr_addr, wr_sel};
  assign rd_key     = {rd_addr, rd_sel};
  // Any commit (exception or ERET) drops a same-cycle MTC0 entirely
  assign mtc0       = wr_en && !except_valid;
  assign commit     = except_valid && !except_eret;
  assign eret       = except_valid && except_eret;
  assign count_wr   = mtc0 && (wr_key == KeyCount);
  assign compare_wr = mtc0 && (wr_key == KeyCompare);
  assign tick       = (COUNT_DIV == 32'd1) || div_q;
  assign count_inc  = count_q + 32'd1;
  assign ti_set     = tick && !count_wr && (count_inc == compare_q);

  assign status_word = {9'b0, bev_q, 6'b0, im_q, 5'b0, erl_q, exl_q, ie_q};
  assign cause_word  = {bd_q, ti_q, 6'b0, iv_q, 7'b0, ip_q, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    bev_d           = bev_q;
    erl_d           = erl_q;
    exl_d           = exl_q;
    ie_d            = ie_q;
    im_d            = im_q;
    bd_d            = bd_q;
    ti_d            = ti_q;
    iv_d            = iv_q;
    ip_d            = ip_q;
    exc_code_d      = exc_code_q;
    count_d         = count_q;
    compare_d       = compare_q;
    epc_d           = epc_q;
    error_epc_d     = error_epc_q;
    badvaddr_d      = badvaddr_q;
    ebase_d         = ebase_q;
    div_d           = tick ? 1'b0 : 1'b1;
    interrupt_req_d = interrupt_req_q;

    if (tick) begin
      count_d = count_inc;
    end

    if (mtc0) begin
      case (wr_key)
        KeyCount: begin
          count_d = wr_data;
          div_d   = 1'b0;
        end
        KeyCompare: compare_d = wr_data;
        KeyStatus: begin
          bev_d = wr_data[22];
          im_d  = wr_data[15:8];
          erl_d = wr_data[2];
          exl_d = wr_data[1];
          ie_d  = wr_data[0];
        end
        KeyCause: begin
          ip_d[1:0] = wr_data[9:8];
          iv_d      = wr_data[23];
        end
        KeyEpc:      epc_d       = wr_data;
        KeyEbase:    ebase_d     = wr_data[29:12];
        KeyErrorEpc: error_epc_d = wr_data;
        default: ;
      endcase
    end

    if (commit) begin
      // Nested exceptions keep the original return point
      if (!exl_q) begin
        epc_d = except_delayslot ? except_pc - 32'd4 : except_pc;
        bd_d  = except_delayslot;
      end
      exc_code_d = except_code;
      exl_d      = 1'b1;
      if (except_code >= 5'd1 && except_code <= 5'd5) begin
        badvaddr_d = except_extra;
      end
    end else if (eret) begin
      if (erl_q) begin
        erl_d = 1'b0;
      end else begin
        exl_d = 1'b0;
      end
    end

    // Compare write clears TI even if the same increment would have matched
    if (compare_wr) begin
      ti_d = 1'b0;
    end else if (ti_set) begin
      ti_d = 1'b1;
    end

    ip_d[7:2]       = {hw_int_q[5] | ti_d, hw_int_q[4:0]};
    interrupt_req_d = ip_d & im_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bev_q           <= 1'b1;
      erl_q           <= 1'b1;
      exl_q           <= 1'b0;
      ie_q            <= 1'b0;
      im_q            <= 8'h00;
      bd_q            <= 1'b0;
      ti_q            <= 1'b0;
      iv_q            <= 1'b0;
      ip_q            <= 8'h00;
      exc_code_q      <= 5'd0;
      count_q         <= 32'd0;
      compare_q       <= 32'd0;
      epc_q           <= 32'd0;
      error_epc_q     <= 32'd0;
      badvaddr_q      <= 32'd0;
      ebase_q         <= EBASE_RESET[29:12];
      div_q           <= 1'b0;
      hw_int_q        <= 6'd0;
      interrupt_req_q <= 8'h00;
    end else begin
      bev_q           <= bev_d;
      erl_q           <= erl_d;
      exl_q           <= exl_d;
      ie_q            <= ie_d;
      im_q            <= im_d;
      bd_q            <= bd_d;
      ti_q            <= ti_d;
      iv_q            <= iv_d;
      ip_q            <= ip_d;
      exc_code_q      <= exc_code_d;
      count_q         <= count_d;
      compare_q       <= compare_d;
      epc_q           <= epc_d;
      error_epc_q     <= error_epc_d;
      badvaddr_q      <= badvaddr_d;
      ebase_q         <= ebase_d;
      div_q           <= div_d;
      hw_int_q        <= hw_int;
      interrupt_req_q <= interrupt_req_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (rd_key)
      KeyBadVAddr: rd_data = badvaddr_q;
      KeyCount:    rd_data = count_q;
      KeyCompare:  rd_data = compare_q;
      KeyStatus:   rd_data = status_word;
      KeyCause:    rd_data = cause_word;
      KeyEpc:      rd_data = epc_q;
      KeyEbase:    rd_data = {2'b10, ebase_q, 12'h000};
      KeyErrorEpc: rd_data = error_epc_q;
      default:     rd_data = 32'd0;
    endcase
  end

  assign cp0_status    = status_word;
  assign cp0_cause     = cause_word;
  assign cp0_epc       = epc_q;
  assign cp0_error_epc = error_epc_q;
  assign cp0_ebase     = {2'b10, ebase_q, 12'h000};
  assign interrupt_req = interrupt_req_q;

endmodule
